// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the PC-indexed 2-bit direction predictor.
package branch_predictor_pkg;

    localparam int unsigned PHT_LOG_DEF = 6;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    // MSB of the counter is the taken/not-taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt2_t;

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/decode-side connection of the branch predictor; clk/rst stay outside.
interface branch_predictor_if;

    logic [31:0] pcF;
    logic [5:0]  opF;
    logic        stallD;
    logic        flushD;
    logic        branchD;
    logic        pcsrcD;
    logic        pred_takenF;
    logic        pred_takenD;
    logic        mispredictD;
    logic        mispred_dirD;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    modport master (
        output pcF, opF, stallD, flushD, branchD, pcsrcD,
        input  pred_takenF, pred_takenD, mispredictD, mispred_dirD,
        input  branch_cnt, mispred_cnt
    );

    modport slave (
        input  pcF, opF, stallD, flushD, branchD, pcsrcD,
        output pred_takenF, pred_takenD, mispredictD, mispred_dirD,
        output branch_cnt, mispred_cnt
    );

endinterface

// File: rtl/branch_predictor_sat_cnt2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_cnt2
    import branch_predictor_pkg::*;
(
    input  cnt2_t state,
    input  logic  taken,
    output cnt2_t state_next
);

    always_comb begin
        state_next = state;
        unique case (state)
            SNT: state_next = taken ? WNT : SNT;
            WNT: state_next = taken ? WT  : SNT;
            WT:  state_next = taken ? ST  : WNT;
            ST:  state_next = taken ? ST  : WT;
            default: state_next = state;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: PC-indexed PHT of 2-bit counters,
// F->D prediction register, decode-stage resolution and performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned PHT_LOG    = PHT_LOG_DEF,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);

    localparam int unsigned PHT_SIZE = 2 ** PHT_LOG;

    cnt2_t              pht [PHT_SIZE];
    cnt2_t              pht_rd;
    cnt2_t              pht_upd;

    logic [PHT_LOG-1:0] idx_f;
    logic               isbr_f;
    logic               pred_taken_f;

    logic               valid_d;
    logic               pred_d;
    logic [PHT_LOG-1:0] idx_d;

    logic               resolve_d;
    logic               pred_taken_d;
    logic               mispredict_d;

    logic [31:0]        branch_cnt;
    logic [31:0]        mispred_cnt;

    // Word-aligned PC bits outside the index do not affect prediction.
    logic               unused_pc_bits;
    assign unused_pc_bits = ^{bp.pcF[31:PHT_LOG+2], bp.pcF[1:0]};

    // Fetch: asynchronous read, no bypass of a same-cycle update.
    always_comb begin
        idx_f        = bp.pcF[PHT_LOG+1:2];
        isbr_f       = is_branch_op(bp.opF);
        pht_rd       = pht[idx_f];
        pred_taken_f = isbr_f & pht_rd[1];
    end

    always_comb begin
        resolve_d    = bp.branchD & ~bp.stallD;
        pred_taken_d = valid_d & pred_d;
        mispredict_d = resolve_d & (pred_taken_d ^ bp.pcsrcD);
    end

    sat_cnt2 u_sat_cnt2 (
        .state      (pht[idx_d]),
        .taken      (bp.pcsrcD),
        .state_next (pht_upd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHT_SIZE; i++) begin
                pht[i[PHT_LOG-1:0]] <= cnt2_t'(INIT_STATE);
            end
        end else if (resolve_d) begin
            pht[idx_d] <= pht_upd;
        end
    end

    // A mispredict drops the wrong-path fetch exactly like a flush; both beat stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_d <= 1'b0;
            pred_d  <= 1'b0;
            idx_d   <= '0;
        end else if (bp.flushD || mispredict_d) begin
            valid_d <= 1'b0;
            pred_d  <= 1'b0;
            idx_d   <= '0;
        end else if (!bp.stallD) begin
            valid_d <= isbr_f;
            pred_d  <= pred_taken_f;
            idx_d   <= idx_f;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (resolve_d) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict_d) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

    assign bp.pred_takenF  = pred_taken_f;
    assign bp.pred_takenD  = pred_taken_d;
    assign bp.mispredictD  = mispredict_d;
    assign bp.mispred_dirD = bp.pcsrcD;
    assign bp.branch_cnt   = branch_cnt;
    assign bp.mispred_cnt  = mispred_cnt;

endmodule
